warp_scheduler: RTL and testbench
=================================

# warp_scheduler

Per-CTA warp scheduler sitting directly upstream of the thread controller in the SIMT front end. It accepts a kernel launch and tracks a per-warp lifecycle state (idle/active/barrier/exited). Each cycle it picks one ready warp round-robin for the issue stage, which produces the issued-warp fields the thread controller consumes. It holds warps at a CTA-wide barrier, retires warps on the thread controller's exit report, and pulses done when every warp has exited.

## Interface
- NUM_WARP, 4, warps per CTA (power of two)
- NUM_WARP_LOG, 2, log2(NUM_WARP)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- launch_valid_i  in  1  kernel launch request
- launch_ready_o  out  1  scheduler idle, launch accepted when both high
- warpEnMask_i  in  NUM_WARP  warps participating in the launch
- stall_i  in  1  issue stage stalled; hold issue outputs
- warpReady_i  in  NUM_WARP  per-warp instruction buffer/scoreboard ready
- issueValid_o  out  1  registered: issueWarp_o valid
- issueWarp_o  out  NUM_WARP_LOG  registered selected warp
- barrierArrive_i  in  1  issued instruction was a CTA barrier
- barrierWarp_i  in  NUM_WARP_LOG  warp arriving at the barrier
- exitValid_i  in  1  warp fully exited (thread controller ctaExit_o)
- exitWarp_i  in  NUM_WARP_LOG  exited warp (thread controller exitWarp_o)
- barrierRelease_o  out  1  one-cycle pulse: barrier released
- activeMask_o  out  NUM_WARP  warps in ACTIVE or BARRIER
- kernelDone_o  out  1  one-cycle pulse: all warps exited

## Operation
- Global FSM: S_IDLE -> S_RUN on launch handshake. S_RUN -> S_DONE when no warp is ACTIVE or BARRIER. S_DONE -> S_IDLE unconditionally, asserting kernelDone_o for that cycle.
- launch_ready_o = (state == S_IDLE). On launch, warps in warpEnMask_i enter ACTIVE and the rest enter EXITED. A launch with an all-zero mask goes S_RUN -> S_DONE, so kernelDone_o pulses 2 cycles after the handshake.
- Per-warp states: IDLE, ACTIVE, BARRIER, EXITED. After reset every warp is IDLE.
- Eligible = ACTIVE & warpReady_i & ~(arriving warp this cycle).
- Selection: first eligible warp strictly after rrPtr, wrapping modulo NUM_WARP. rrPtr is set to the selected warp on every issue.
- barrierArrive_i moves an ACTIVE warp to BARRIER. Arrive for a warp in any other state is ignored.
- exitValid_i moves an ACTIVE or BARRIER warp to EXITED. Exit for an IDLE/EXITED warp is ignored. If exit and arrive hit the same warp in one cycle, exit wins.
- Release condition, evaluated on next-state values: the BARRIER count is nonzero and equals the count of non-EXITED warps. On release, all BARRIER warps go to ACTIVE on the next edge and barrierRelease_o pulses one cycle. A warp exiting can therefore trigger the release.
- Counts are NUM_WARP_LOG+1 bits wide; no overflow is possible.
- Arrive, exit and release are processed regardless of stall_i.

## Timing
- Reset values: issueValid_o=0, issueWarp_o=0, barrierRelease_o=0, kernelDone_o=0, activeMask_o=0, launch_ready_o=1 (S_IDLE), rrPtr=NUM_WARP-1 so the first pick is warp 0.
- Issue latency is 1 cycle: the selection from the cycle-N state appears on the outputs after edge N.
- While stall_i=1: issueValid_o, issueWarp_o and rrPtr hold.
- A warp that arrives at the barrier in cycle N is never issued on edge N.
- Released warps are eligible from cycle N+1 after the release edge.
- Reset asserted mid-kernel: everything returns to reset values on the next edge. No done pulse is generated.

## Configuration
- WS_GREEDY_EN defined: greedy-then-round-robin. If the last issued warp is still eligible, it is reselected; otherwise normal round-robin from rrPtr.
- WS_GREEDY_EN undefined: strict round-robin; the last warp is reselected only when it is the sole eligible warp.

## Structure
- The shared parameter header (GPGPUParam.v) holds the warp-state encodings (WS_IDLE=0, WS_ACTIVE=1, WS_BARRIER=2, WS_EXITED=3), the FSM state encodings, NUM_WARP and NUM_WARP_LOG.
- One sub-module, rr_arbiter: request vector plus pointer in, one-hot grant and encoded index out, purely combinational. It is reusable by the issue stage.

## Test plan
- Launch with mask 4'b1111 and all ready, no stall -> issueWarp_o sequence 0,1,2,3,0 on consecutive cycles, issueValid_o=1 throughout.
- Launch with mask 4'b0101 and all ready -> issues alternate 0,2,0,2. activeMask_o=4'b0101.
- Warps 0..2 arrive in successive cycles with warp 3 still active -> those warps are never reissued. Warp 3 arrives -> barrierRelease_o pulses once, and round-robin resumes at the warp after rrPtr.
- Warps 0,1,2 in BARRIER, then exitValid_i with warp 3 -> release pulse in the same update. Then exit warps 0,1,2 -> kernelDone_o pulses exactly once, launch_ready_o=1 the next cycle.
- stall_i held 3 cycles mid-run -> issueWarp_o is unchanged. Exit of warp 1 during the stall is still applied: warp 1 is not issued after the stall.
- Reset asserted mid-run with 2 warps in BARRIER -> next cycle all outputs are at reset values, no kernelDone_o. A new launch works normally. Repeat this scenario with WS_GREEDY_EN defined: warp 0 is issued repeatedly while warpReady_i[0]=1.

Source files
------------

// File: rtl/warp_scheduler_pkg.sv
// rtl/warp_scheduler_pkg.sv - shared warp-state and FSM encodings for the warp scheduler
package warp_scheduler_pkg;

    localparam int WS_NUM_WARP     = 4;
    localparam int WS_NUM_WARP_LOG = 2;

    typedef enum logic [1:0] {
        WS_IDLE    = 2'd0,
        WS_ACTIVE  = 2'd1,
        WS_BARRIER = 2'd2,
        WS_EXITED  = 2'd3
    } warp_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// rtl/warp_scheduler_rr_arbiter.sv - combinational round-robin arbiter (first request strictly after ptr)
module rr_arbiter #(
    parameter int N   = 4,
    parameter int LOG = 2
) (
    input  logic [N-1:0]   req,
    input  logic [LOG-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [LOG-1:0] index
);

    logic [LOG-1:0] cand;
    logic           found;

    // N is a power of two, so the LOG-bit add wraps modulo N; i == N lands back on ptr.
    always_comb begin
        grant = '0;
        index = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = ptr + LOG'(i);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - per-CTA warp scheduler: launch, round-robin issue, CTA barrier, exit/done.
// Optional WS_GREEDY_EN: keep reissuing the last warp while it stays eligible.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARP     = WS_NUM_WARP,
    parameter int NUM_WARP_LOG = WS_NUM_WARP_LOG
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    launch_valid_i,
    output logic                    launch_ready_o,
    input  logic [NUM_WARP-1:0]     warpEnMask_i,
    input  logic                    stall_i,
    input  logic [NUM_WARP-1:0]     warpReady_i,
    output logic                    issueValid_o,
    output logic [NUM_WARP_LOG-1:0] issueWarp_o,
    input  logic                    barrierArrive_i,
    input  logic [NUM_WARP_LOG-1:0] barrierWarp_i,
    input  logic                    exitValid_i,
    input  logic [NUM_WARP_LOG-1:0] exitWarp_i,
    output logic                    barrierRelease_o,
    output logic [NUM_WARP-1:0]     activeMask_o,
    output logic                    kernelDone_o
);

    localparam int CW = NUM_WARP_LOG + 1;

    sched_state_t state, state_next;
    warp_state_t  ws      [NUM_WARP];
    warp_state_t  ws_next [NUM_WARP];

    logic [NUM_WARP_LOG-1:0] rr_ptr, issue_warp, sel_warp, arb_index;
    logic [NUM_WARP-1:0]     eligible, arb_grant, active_mask;
    logic                    issue_valid, release_q, release_now, sel_valid, launch_fire;
    logic [CW-1:0]           bar_cnt, live_cnt;

    // A warp arriving at the barrier this cycle must not be picked on the same edge.
    always_comb begin
        eligible    = '0;
        active_mask = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            eligible[w]    = (ws[w] == WS_ACTIVE) && warpReady_i[w] &&
                             !(barrierArrive_i && barrierWarp_i == NUM_WARP_LOG'(w));
            active_mask[w] = (ws[w] == WS_ACTIVE) || (ws[w] == WS_BARRIER);
        end
    end

    rr_arbiter #(.N(NUM_WARP), .LOG(NUM_WARP_LOG)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .index (arb_index)
    );

    always_comb begin
        sel_valid = |arb_grant;
        sel_warp  = arb_index;
`ifdef WS_GREEDY_EN
        if (issue_valid && eligible[issue_warp]) begin
            sel_valid = 1'b1;
            sel_warp  = issue_warp;
        end
`endif
    end

    // Per-warp transitions; exit beats arrive, and release is judged on the post-update states.
    always_comb begin
        bar_cnt     = '0;
        live_cnt    = '0;
        release_now = 1'b0;
        for (int w = 0; w < NUM_WARP; w++) begin
            ws_next[w] = ws[w];
            if (launch_fire) begin
                ws_next[w] = warpEnMask_i[w] ? WS_ACTIVE : WS_EXITED;
            end else if (exitValid_i && exitWarp_i == NUM_WARP_LOG'(w) &&
                         (ws[w] == WS_ACTIVE || ws[w] == WS_BARRIER)) begin
                ws_next[w] = WS_EXITED;
            end else if (barrierArrive_i && barrierWarp_i == NUM_WARP_LOG'(w) &&
                         ws[w] == WS_ACTIVE) begin
                ws_next[w] = WS_BARRIER;
            end
        end
        for (int w = 0; w < NUM_WARP; w++) begin
            if (ws_next[w] == WS_BARRIER) bar_cnt  = bar_cnt + CW'(1);
            if (ws_next[w] != WS_EXITED)  live_cnt = live_cnt + CW'(1);
        end
        release_now = (bar_cnt != '0) && (bar_cnt == live_cnt);
        if (release_now) begin
            for (int w = 0; w < NUM_WARP; w++) begin
                if (ws_next[w] == WS_BARRIER) ws_next[w] = WS_ACTIVE;
            end
        end
    end

    always_comb begin
        state_next     = state;
        launch_ready_o = 1'b0;
        kernelDone_o   = 1'b0;
        launch_fire    = 1'b0;
        case (state)
            S_IDLE: begin
                launch_ready_o = 1'b1;
                launch_fire    = launch_valid_i;
                if (launch_valid_i) state_next = S_RUN;
            end
            S_RUN: begin
                if (active_mask == '0) state_next = S_DONE;
            end
            S_DONE: begin
                kernelDone_o = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= NUM_WARP_LOG'(NUM_WARP - 1);
            issue_valid <= 1'b0;
            issue_warp  <= '0;
            release_q   <= 1'b0;
            for (int w = 0; w < NUM_WARP; w++) ws[w] <= WS_IDLE;
        end else begin
            state     <= state_next;
            release_q <= release_now;
            for (int w = 0; w < NUM_WARP; w++) ws[w] <= ws_next[w];
            if (!stall_i) begin
                issue_valid <= sel_valid;
                if (sel_valid) begin
                    issue_warp <= sel_warp;
                    rr_ptr     <= sel_warp;
                end
            end
        end
    end

    assign issueValid_o     = issue_valid;
    assign issueWarp_o      = issue_warp;
    assign barrierRelease_o = release_q;
    assign activeMask_o     = active_mask;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - scoreboard bench for warp_scheduler (expectations follow WS_GREEDY_EN)
module tb_warp_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       launch_valid_i = 1'b0;
    logic       stall_i = 1'b0;
    logic       barrierArrive_i = 1'b0;
    logic       exitValid_i = 1'b0;
    logic [3:0] warpEnMask_i = '0;
    logic [3:0] warpReady_i = '0;
    logic [1:0] barrierWarp_i = '0;
    logic [1:0] exitWarp_i = '0;
    logic       launch_ready_o, issueValid_o, barrierRelease_o, kernelDone_o;
    logic [1:0] issueWarp_o;
    logic [3:0] activeMask_o;

    int checks = 0;
    int passed = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    warp_scheduler dut (
        .clk              (clk),
        .reset            (reset),
        .launch_valid_i   (launch_valid_i),
        .launch_ready_o   (launch_ready_o),
        .warpEnMask_i     (warpEnMask_i),
        .stall_i          (stall_i),
        .warpReady_i      (warpReady_i),
        .issueValid_o     (issueValid_o),
        .issueWarp_o      (issueWarp_o),
        .barrierArrive_i  (barrierArrive_i),
        .barrierWarp_i    (barrierWarp_i),
        .exitValid_i      (exitValid_i),
        .exitWarp_i       (exitWarp_i),
        .barrierRelease_o (barrierRelease_o),
        .activeMask_o     (activeMask_o),
        .kernelDone_o     (kernelDone_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pop_exp();
        if (exp_q.size() == 0) return -1;
        return exp_q.pop_front();
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        launch_valid_i = 1'b0; stall_i = 1'b0; barrierArrive_i = 1'b0; exitValid_i = 1'b0;
        warpEnMask_i = '0; warpReady_i = '0; barrierWarp_i = '0; exitWarp_i = '0;
        tick; tick;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic launch(input logic [3:0] m);
        launch_valid_i = 1'b1;
        warpEnMask_i   = m;
        tick;
        launch_valid_i = 1'b0;
        warpEnMask_i   = '0;
    endtask

    task automatic finish_kernel(input string name, input logic [3:0] m);
        int dones = 0;
        for (int w = 0; w < 4; w++) begin
            if (m[w]) begin
                exitValid_i = 1'b1;
                exitWarp_i  = 2'(w);
                tick;
            end
        end
        exitValid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (kernelDone_o === 1'b1) dones++;
        end
        checks++;
        if (dones !== 1) $display("FAIL %s_done_pulses: got %0d, expected 1", name, dones);
        else passed++;
        checks++;
        if (launch_ready_o !== 1'b1) $display("FAIL %s_ready_after_done: got %0b, expected 1", name, launch_ready_o);
        else passed++;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (issueValid_o !== 1'b0) $display("FAIL rst_issueValid: got %0b, expected 0", issueValid_o); else passed++;
        checks++; if (issueWarp_o !== 2'd0) $display("FAIL rst_issueWarp: got %0d, expected 0", issueWarp_o); else passed++;
        checks++; if (barrierRelease_o !== 1'b0) $display("FAIL rst_release: got %0b, expected 0", barrierRelease_o); else passed++;
        checks++; if (kernelDone_o !== 1'b0) $display("FAIL rst_done: got %0b, expected 0", kernelDone_o); else passed++;
        checks++; if (activeMask_o !== 4'b0000) $display("FAIL rst_activeMask: got %b, expected 0000", activeMask_o); else passed++;
        checks++; if (launch_ready_o !== 1'b1) $display("FAIL rst_ready: got %0b, expected 1", launch_ready_o); else passed++;
    endtask

    task automatic test_round_robin;
        int e;
        do_reset;
        warpReady_i = 4'b1111;
        launch(4'b1111);
        checks++; if (activeMask_o !== 4'b1111) $display("FAIL rr_activeMask: got %b, expected 1111", activeMask_o); else passed++;
        checks++; if (launch_ready_o !== 1'b0) $display("FAIL rr_ready_busy: got %0b, expected 0", launch_ready_o); else passed++;
`ifdef WS_GREEDY_EN
        exp_q = '{0, 0, 0, 0, 0};
`else
        exp_q = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            tick;
            e = pop_exp();
            checks++;
            if (e < 0 || issueValid_o !== 1'b1 || issueWarp_o !== 2'(e))
                $display("FAIL rr_issue[%0d]: valid=%0b warp=%0d, expected valid=1 warp=%0d", i, issueValid_o, issueWarp_o, e);
            else passed++;
        end
        finish_kernel("rr", 4'b1111);
    endtask

    task automatic test_mask;
        int e;
        do_reset;
        warpReady_i = 4'b1111;
        launch(4'b0101);
        checks++; if (activeMask_o !== 4'b0101) $display("FAIL mask_activeMask: got %b, expected 0101", activeMask_o); else passed++;
`ifdef WS_GREEDY_EN
        exp_q = '{0, 0, 0, 0};
`else
        exp_q = '{0, 2, 0, 2};
`endif
        for (int i = 0; i < 4; i++) begin
            tick;
            e = pop_exp();
            checks++;
            if (e < 0 || issueValid_o !== 1'b1 || issueWarp_o !== 2'(e))
                $display("FAIL mask_issue[%0d]: valid=%0b warp=%0d, expected valid=1 warp=%0d", i, issueValid_o, issueWarp_o, e);
            else passed++;
        end
        finish_kernel("mask", 4'b0101);
    endtask

    task automatic test_zero_mask;
        do_reset;
        launch(4'b0000);
        checks++; if (kernelDone_o !== 1'b0) $display("FAIL zero_done_early: got %0b, expected 0", kernelDone_o); else passed++;
        tick;
        checks++; if (kernelDone_o !== 1'b1) $display("FAIL zero_done: got %0b, expected 1", kernelDone_o); else passed++;
        tick;
        checks++; if (kernelDone_o !== 1'b0 || launch_ready_o !== 1'b1)
            $display("FAIL zero_after: done=%0b ready=%0b, expected done=0 ready=1", kernelDone_o, launch_ready_o);
        else passed++;
    endtask

    task automatic test_barrier;
        int e;
        do_reset;
        warpReady_i = 4'b1111;
        launch(4'b1111);
        exp_q = '{1, 2, 3, 3};
        for (int i = 0; i < 4; i++) begin
            barrierArrive_i = (i != 3);
            barrierWarp_i   = 2'(i);
            tick;
            e = pop_exp();
            checks++;
            if (e < 0 || issueValid_o !== 1'b1 || issueWarp_o !== 2'(e))
                $display("FAIL bar_issue[%0d]: valid=%0b warp=%0d, expected valid=1 warp=%0d", i, issueValid_o, issueWarp_o, e);
            else passed++;
            checks++;
            if (barrierRelease_o !== 1'b0 || activeMask_o !== 4'b1111)
                $display("FAIL bar_hold[%0d]: release=%0b mask=%b, expected release=0 mask=1111", i, barrierRelease_o, activeMask_o);
            else passed++;
        end
        barrierArrive_i = 1'b1;
        barrierWarp_i   = 2'd3;
        tick;
        barrierArrive_i = 1'b0;
        checks++;
        if (barrierRelease_o !== 1'b1 || issueValid_o !== 1'b0)
            $display("FAIL bar_release: release=%0b valid=%0b, expected release=1 valid=0", barrierRelease_o, issueValid_o);
        else passed++;
`ifdef WS_GREEDY_EN
        exp_q = '{0, 0};
`else
        exp_q = '{0, 1};
`endif
        for (int i = 0; i < 2; i++) begin
            tick;
            e = pop_exp();
            checks++;
            if (e < 0 || issueValid_o !== 1'b1 || issueWarp_o !== 2'(e) || barrierRelease_o !== 1'b0)
                $display("FAIL bar_resume[%0d]: valid=%0b warp=%0d release=%0b, expected valid=1 warp=%0d release=0",
                         i, issueValid_o, issueWarp_o, barrierRelease_o, e);
            else passed++;
        end
    endtask

    task automatic test_exit_release;
        do_reset;
        warpReady_i = 4'b1111;
        launch(4'b1111);
        for (int i = 0; i < 3; i++) begin
            barrierArrive_i = 1'b1;
            barrierWarp_i   = 2'(i);
            tick;
        end
        barrierArrive_i = 1'b0;
        exitValid_i     = 1'b1;
        exitWarp_i      = 2'd3;
        tick;
        exitValid_i     = 1'b0;
        checks++;
        if (barrierRelease_o !== 1'b1 || activeMask_o !== 4'b0111)
            $display("FAIL exit_release: release=%0b mask=%b, expected release=1 mask=0111", barrierRelease_o, activeMask_o);
        else passed++;
        finish_kernel("exitrel", 4'b0111);
    endtask

    task automatic test_stall;
        int e;
        do_reset;
        warpReady_i = 4'b1111;
        launch(4'b1111);
        tick;
        checks++;
        if (issueValid_o !== 1'b1 || issueWarp_o !== 2'd0)
            $display("FAIL stall_first: valid=%0b warp=%0d, expected valid=1 warp=0", issueValid_o, issueWarp_o);
        else passed++;
        stall_i     = 1'b1;
        exitValid_i = 1'b1;
        exitWarp_i  = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick;
            exitValid_i = 1'b0;
            checks++;
            if (issueValid_o !== 1'b1 || issueWarp_o !== 2'd0)
                $display("FAIL stall_hold[%0d]: valid=%0b warp=%0d, expected valid=1 warp=0", i, issueValid_o, issueWarp_o);
            else passed++;
        end
        stall_i = 1'b0;
        checks++;
        if (activeMask_o !== 4'b1101) $display("FAIL stall_exit_mask: got %b, expected 1101", activeMask_o);
        else passed++;
`ifdef WS_GREEDY_EN
        exp_q = '{0, 0, 0, 0};
`else
        exp_q = '{2, 3, 0, 2};
`endif
        for (int i = 0; i < 4; i++) begin
            tick;
            e = pop_exp();
            checks++;
            if (e < 0 || issueValid_o !== 1'b1 || issueWarp_o !== 2'(e))
                $display("FAIL stall_after[%0d]: valid=%0b warp=%0d, expected valid=1 warp=%0d", i, issueValid_o, issueWarp_o, e);
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        int e;
        int dones = 0;
        do_reset;
        warpReady_i = 4'b1111;
        launch(4'b1111);
        for (int i = 0; i < 2; i++) begin
            barrierArrive_i = 1'b1;
            barrierWarp_i   = 2'(i);
            tick;
        end
        barrierArrive_i = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (issueValid_o !== 1'b0 || issueWarp_o !== 2'd0 || barrierRelease_o !== 1'b0 ||
            kernelDone_o !== 1'b0 || activeMask_o !== 4'b0000 || launch_ready_o !== 1'b1)
            $display("FAIL midrst_outputs: valid=%0b warp=%0d rel=%0b done=%0b mask=%b ready=%0b, expected 0 0 0 0 0000 1",
                     issueValid_o, issueWarp_o, barrierRelease_o, kernelDone_o, activeMask_o, launch_ready_o);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (kernelDone_o === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) $display("FAIL midrst_no_done: got %0d pulses, expected 0", dones);
        else passed++;
        launch(4'b0011);
        checks++;
        if (activeMask_o !== 4'b0011) $display("FAIL midrst_relaunch_mask: got %b, expected 0011", activeMask_o);
        else passed++;
`ifdef WS_GREEDY_EN
        exp_q = '{0, 0, 0};
`else
        exp_q = '{0, 1, 0};
`endif
        for (int i = 0; i < 3; i++) begin
            tick;
            e = pop_exp();
            checks++;
            if (e < 0 || issueValid_o !== 1'b1 || issueWarp_o !== 2'(e))
                $display("FAIL midrst_issue[%0d]: valid=%0b warp=%0d, expected valid=1 warp=%0d", i, issueValid_o, issueWarp_o, e);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_mask;
        test_zero_mask;
        test_barrier;
        test_exit_release;
        test_stall;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
